// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 8;

  localparam int unsigned CPU_PORT = 0;
  localparam int unsigned DBG_PORT = 1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker; round-robin when ARB_RR_EN is defined, else CPU-first priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_winner,
  output logic [1:0] winner
);

`ifdef ARB_RR_EN
  // A zero last_winner (after reset) favours the CPU port.
  always_comb begin
    winner = '0;
    if (req == 2'b11) begin
      winner = last_winner[CPU_PORT] ? 2'b10 : 2'b01;
    end else begin
      winner = req;
    end
  end
`else
  logic [1:0] unused_last;
  assign unused_last = last_winner;

  always_comb begin
    winner = '0;
    if (req[CPU_PORT]) begin
      winner[CPU_PORT] = 1'b1;
    end else if (req[DBG_PORT]) begin
      winner[DBG_PORT] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one 32x8 memory between CPU (port 0) and debug loader (port 1).
// Define ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out
);

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cmd_we_q, cmd_we_d;
  logic                cmd_port_q, cmd_port_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [1:0]          win;
  logic [1:0]          last_winner;
  logic                grant;
  logic                in_access;

  arb_pick u_pick (
    .req         (req),
    .last_winner (last_winner),
    .winner      (win)
  );

  assign grant = (state_q != StAccess) && (|req);

`ifdef ARB_RR_EN
  logic [1:0] last_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= '0;
    end else if (grant) begin
      last_q <= win;
    end
  end

  assign last_winner = last_q;
`else
  assign last_winner = '0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    ack_d       = '0;
    rdata_d     = rdata_q;
    cmd_we_d    = cmd_we_q;
    cmd_port_d  = cmd_port_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;

    unique case (state_q)
      StIdle, StResp: begin
        if (grant) begin
          state_d     = StAccess;
          gnt_d       = win;
          cmd_port_d  = win[DBG_PORT];
          cmd_we_d    = win[DBG_PORT] ? we[DBG_PORT] : we[CPU_PORT];
          cmd_addr_d  = win[DBG_PORT] ? addr1 : addr0;
          cmd_wdata_d = win[DBG_PORT] ? wdata1 : wdata0;
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        state_d = StResp;
        ack_d   = cmd_port_q ? 2'b10 : 2'b01;
        if (!cmd_we_q) begin
          rdata_d = mem_out;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      cmd_we_q    <= 1'b0;
      cmd_port_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      cmd_we_q    <= cmd_we_d;
      cmd_port_q  <= cmd_port_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  assign in_access = (state_q == StAccess);

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign mem_read  = in_access && !cmd_we_q;
  // Gating with rst keeps a write from committing if reset lands in its access cycle.
  assign mem_write = in_access && cmd_we_q && rst;

endmodule
